matrix_result_display: RTL and testbench

Downstream display stage for the matrix-sum datapath. On a start pulse from the compute/write-back stage, it fetches the 256-bit result word from the single-port RAM and shows it byte-by-byte on the 8 board LEDs. Each byte is held for a fixed prescaled interval. The block replaces ad-hoc LED scanning with a handshaked FSM that has defined reset, wrap and completion behaviour.

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_result_display_if.sv | 41 ++++
 rtl/matrix_result_display_tick_prescaler.sv | 39 +++
 rtl/matrix_result_display.sv | 133 +++++++++++++
 tb/tb_matrix_result_display.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared constants for the matrix-sum datapath (load, sum and display stages)
// and the state encoding of the result display FSM.
// -----------------------------------------------------------------------------
package matrix_pkg;

  // Width of one RAM word / one result matrix, and of one displayed byte.
  localparam int MATRIX_W = 256;
  localparam int BYTE_W   = 8;

  // RAM word addresses used by the datapath stages.
  localparam int OPB_BASE    = 32;
  localparam int RESULT_BASE = 64;

  // Display FSM states. Explicit 2-bit encoding so the values can be mirrored
  // by plain logic constants in legacy-style code.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2,
    DONE  = 2'd3
  } disp_state_t;

endpackage : matrix_pkg

// File: rtl/matrix_result_display_if.sv
// -----------------------------------------------------------------------------
// matrix_result_display_if
// Groups the request, RAM read and LED display signals of the result display.
//   start      : one-cycle request from the compute stage
//   repeat_en  : 1 = loop the bytes until reset, 0 = single pass
//   ram_addr   : registered RAM read address (display -> RAM)
//   ram_rdata  : RAM read data (RAM -> display)
//   leds       : displayed byte
//   byte_idx   : index of the byte currently shown
//   busy       : high while fetching or showing
//   done       : one-cycle pulse at the end of a single pass
// slave modport = display block, master modport = surrounding system.
// -----------------------------------------------------------------------------
interface matrix_result_display_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 8
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic              start;
  logic              repeat_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [7:0]        leds;
  logic [IDX_W-1:0]  byte_idx;
  logic              busy;
  logic              done;

  modport master (
    output start, repeat_en, ram_rdata,
    input  ram_addr, leds, byte_idx, busy, done
  );

  modport slave (
    input  start, repeat_en, ram_rdata,
    output ram_addr, leds, byte_idx, busy, done
  );

endinterface : matrix_result_display_if

// File: rtl/matrix_result_display_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running modulo-TICK_DIV counter that sets the per-byte display time.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   clear : forces the count to 0 (held while the display is not showing)
//   tick  : high while the count is TICK_DIV-1; the count then wraps to 0
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] r_count;
  logic             w_wrap;

  assign w_wrap = (r_count == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear || w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // A cleared counter never reports a tick, so the caller sees a full
  // interval after releasing clear.
  assign tick = w_wrap & ~clear;

endmodule : tick_prescaler

// File: rtl/matrix_result_display.sv
// -----------------------------------------------------------------------------
// matrix_result_display
// On a start request, reads the result word once from RAM into a shadow
// register, then shows it on the LEDs one byte at a time (byte 0 first), each
// byte for TICK_DIV cycles. Either loops forever (repeat_en=1 at the last
// byte) or finishes with a one-cycle done pulse.
//   clk  : system clock
//   rst  : asynchronous active-low reset; aborts any pass without done
//   disp : display interface (slave side), see matrix_result_display_if
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module matrix_result_display
  import matrix_pkg::BYTE_W, matrix_pkg::MATRIX_W;
#(
  parameter int DATA_W      = MATRIX_W,
  parameter int ADDR_W      = 8,
  parameter int RESULT_BASE = matrix_pkg::RESULT_BASE,
  parameter int RAM_LATENCY = 2,
  parameter int TICK_DIV    = 25_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  matrix_result_display_if.slave   disp
);

  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int LAT_W  = $clog2(RAM_LATENCY + 1);

  localparam logic [1:0] ST_IDLE  = matrix_pkg::IDLE;
  localparam logic [1:0] ST_FETCH = matrix_pkg::FETCH;
  localparam logic [1:0] ST_SHOW  = matrix_pkg::SHOW;
  localparam logic [1:0] ST_DONE  = matrix_pkg::DONE;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [DATA_W-1:0] r_shadow;
  logic [7:0]        r_leds;
  logic [IDX_W-1:0]  r_byte_idx;
  logic              r_busy;
  logic              r_done;

  logic              w_lat_hit;
  logic              w_last_byte;
  logic [IDX_W-1:0]  w_next_idx;
  logic              w_tick;
  logic              w_tick_clear;

  // The edge on which the latency count reaches RAM_LATENCY is the capture
  // edge, i.e. the count currently reads RAM_LATENCY-1.
  assign w_lat_hit   = (r_lat_cnt == LAT_W'(RAM_LATENCY - 1));
  assign w_last_byte = (r_byte_idx == IDX_W'(NBYTES - 1));
  assign w_next_idx  = w_last_byte ? '0 : r_byte_idx + 1'b1;

  // The prescaler only runs while a byte is on display; entering SHOW
  // therefore always starts a fresh interval.
  assign w_tick_clear = (r_state != ST_SHOW);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (w_tick_clear),
    .tick  (w_tick)
  );

  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (disp.start) w_next_state = ST_FETCH;
      ST_FETCH: if (w_lat_hit)  w_next_state = ST_SHOW;
      ST_SHOW:  if (w_tick && w_last_byte && !disp.repeat_en) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_ram_addr <= '0;
      r_lat_cnt  <= '0;
      // NOTE: the shadow is a plain register, not a RAM, so it is reset with
      // everything else and a fresh pass never shows stale data.
      r_shadow   <= '0;
      r_leds     <= '0;
      r_byte_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Status flags follow the next state so they line up with r_state.
      r_busy  <= (w_next_state == ST_FETCH) || (w_next_state == ST_SHOW);
      r_done  <= (w_next_state == ST_DONE);

      unique case (r_state)
        ST_IDLE: begin
          if (disp.start) begin
            r_ram_addr <= ADDR_W'(RESULT_BASE);
            r_lat_cnt  <= '0;
          end
        end
        ST_FETCH: begin
          r_lat_cnt <= r_lat_cnt + 1'b1;
          if (w_lat_hit) begin
            r_shadow   <= disp.ram_rdata;
            r_leds     <= disp.ram_rdata[BYTE_W-1:0];
            r_byte_idx <= '0;
          end
        end
        ST_SHOW: begin
          // On the final boundary of a single pass the last byte stays lit.
          if (w_tick && !(w_last_byte && !disp.repeat_en)) begin
            r_byte_idx <= w_next_idx;
            r_leds     <= r_shadow[BYTE_W*int'(w_next_idx) +: BYTE_W];
          end
        end
        default: ;
      endcase
    end
  end

  assign disp.ram_addr = r_ram_addr;
  assign disp.leds     = r_leds;
  assign disp.byte_idx = r_byte_idx;
  assign disp.busy     = r_busy;
  assign disp.done     = r_done;

endmodule : matrix_result_display

// File: tb/tb_matrix_result_display.sv
// -----------------------------------------------------------------------------
// tb_matrix_result_display
// Directed bench for matrix_result_display with TICK_DIV=4, RAM_LATENCY=2.
// Cycle numbering: the start pulse is sampled at edge 0; "cycle n" is the
// interval after edge n-1. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_matrix_result_display;

  localparam int DATA_W   = 256;
  localparam int ADDR_W   = 8;
  localparam int TICK_DIV = 4;
  localparam int RAM_LAT  = 2;
  localparam int BASE     = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem;
  logic [DATA_W-1:0] bytes_data;
  logic [DATA_W-1:0] aa_data;
  logic              inject;
  int                cyc;
  int                n_vec;
  int                n_miss;
  int                done_seen;

  matrix_result_display_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_if ();

  // RAM model: only the result address returns the stored word.
  assign u_if.ram_rdata = (u_if.ram_addr == ADDR_W'(BASE)) ? mem : '0;

  matrix_result_display #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .RESULT_BASE (BASE),
    .RAM_LATENCY (RAM_LAT),
    .TICK_DIV    (TICK_DIV)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (u_if)
  );

  always @(posedge clk) if (u_if.done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Advance to cycle n; the ignored-start stimulus is driven here.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
      u_if.start = inject && (cyc == 2 || cyc == 50 || cyc == 131);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    cyc = 1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_leds"}, 32'(u_if.leds), 32'h0);
    check({tag, "_idx"},  32'(u_if.byte_idx), 32'h0);
    check({tag, "_addr"}, 32'(u_if.ram_addr), 32'h0);
    check({tag, "_busy"}, 32'(u_if.busy), 32'h0);
    check({tag, "_done"}, 32'(u_if.done), 32'h0);
  endtask

  // Expects start to have been sampled at edge 0 with cyc=1; ends at cycle 132.
  task automatic run_single(input string tag, input logic [DATA_W-1:0] data);
    int d0;
    d0 = done_seen;
    goto(1);
    check({tag, "_addr"}, 32'(u_if.ram_addr), 32'(BASE));
    check({tag, "_busy"}, 32'(u_if.busy), 32'h1);
    for (int k = 0; k < 32; k++) begin
      goto(3 + 4 * k);
      check({tag, "_leds_first"}, 32'(u_if.leds), 32'(data[8*k +: 8]));
      check({tag, "_idx"}, 32'(u_if.byte_idx), 32'(k));
      goto(6 + 4 * k);
      check({tag, "_leds_last"}, 32'(u_if.leds), 32'(data[8*k +: 8]));
    end
    goto(130);
    check({tag, "_done_early"}, 32'(u_if.done), 32'h0);
    goto(131);
    check({tag, "_done"}, 32'(u_if.done), 32'h1);
    check({tag, "_busy_end"}, 32'(u_if.busy), 32'h0);
    check({tag, "_leds_end"}, 32'(u_if.leds), 32'(data[255:248]));
    check({tag, "_addr_end"}, 32'(u_if.ram_addr), 32'(BASE));
    goto(132);
    check({tag, "_done_once"}, 32'(u_if.done), 32'h0);
    check({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
  endtask

  initial begin
    n_vec = 0; n_miss = 0; done_seen = 0; cyc = 0; inject = 1'b0;
    u_if.start = 1'b0;
    u_if.repeat_en = 1'b0;
    for (int k = 0; k < 32; k++) bytes_data[8*k +: 8] = 8'(k);
    aa_data = {32{8'hAA}};
    mem = bytes_data;

    // Reset values, during and just after reset.
    repeat (3) @(negedge clk);
    check_idle_zero("rst_hold");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_zero("rst_rel");

    // Reset asserted mid-SHOW while byte 5 is shown.
    start_pulse();
    goto(24);
    check("abort_idx_before", 32'(u_if.byte_idx), 32'd5);
    rst = 1'b0;
    #1;
    check_idle_zero("abort");
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    goto(40);
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_busy", 32'(u_if.busy), 32'h0);

    // Single pass, then back-to-back restart with new data.
    start_pulse();
    run_single("single", bytes_data);
    mem = aa_data;
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    cyc = 1;
    run_single("b2b", aa_data);

    // Extra start pulses at cycles 2, 50 and 131 are ignored.
    mem = bytes_data;
    inject = 1'b1;
    start_pulse();
    run_single("ign", bytes_data);
    inject = 1'b0;
    goto(134);
    check("ign_no_restart", 32'(u_if.busy), 32'h0);

    // Repeat mode: three passes from a single fetch.
    pulse_reset();
    u_if.repeat_en = 1'b1;
    mem = bytes_data;
    begin
      int d0;
      d0 = done_seen;
      start_pulse();
      for (int p = 0; p < 3; p++) begin
        for (int k = 0; k < 32; k++) begin
          goto(3 + 128 * p + 4 * k);
          check("rep_leds", 32'(u_if.leds), 32'(k));
          if (k == 0) check("rep_idx0", 32'(u_if.byte_idx), 32'd0);
          // Later passes must keep showing the captured word.
          if (p == 0 && k == 1) mem = ~bytes_data;
        end
      end
      goto(6 + 128 * 2 + 4 * 31);
      check("rep_last_held", 32'(u_if.leds), 32'h1F);
      check("rep_busy", 32'(u_if.busy), 32'h1);
      check("rep_no_done", 32'(done_seen - d0), 32'd0);
    end

    // Late repeat_en drop while byte 31 is shown ends this pass.
    pulse_reset();
    mem = bytes_data;
    u_if.repeat_en = 1'b1;
    start_pulse();
    goto(127);
    check("late_leds31", 32'(u_if.leds), 32'h1F);
    u_if.repeat_en = 1'b0;
    goto(130);
    check("late_done_early", 32'(u_if.done), 32'h0);
    goto(131);
    check("late_done", 32'(u_if.done), 32'h1);
    check("late_leds_end", 32'(u_if.leds), 32'h1F);
    goto(132);
    check("late_idle", 32'(u_if.busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_matrix_result_display
